// File: rtl/lcd_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : lcd_cmd_sched
// Purpose  : Two-requester round-robin command queue feeding an LCD controller.
// Revision : 1.0
// ============================================================================
module lcd_cmd_sched (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req0_cmd,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [2:0] req1_cmd,
    input  logic       req1_valid,
    output logic       req1_ready,
    output logic [2:0] lcd_cmd,
    output logic       lcd_cmd_valid,
    input  logic       lcd_busy,
    input  logic       lcd_done,
    output logic [2:0] fifo_cnt,
    output logic [7:0] issued_cnt,
    output logic       sealed,
    output logic       all_done,
    output logic       err_timeout
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_IDLE = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_FINISHED  = 3'd5;

    localparam logic [2:0] C_DEPTH    = 3'd4;
    localparam logic [2:0] C_TIMEOUT  = 3'd7;
    localparam logic [2:0] C_WRITE    = 3'd0;
    localparam logic [7:0] C_CNT_MAX  = 8'hFF;

    logic [3:0] r_mem [0:3];
    logic [1:0] r_wr_ptr;
    logic [1:0] r_rd_ptr;
    logic [2:0] r_cnt;
    logic       r_rr;
    logic       r_sealed;
    logic       r_err;
    logic [2:0] r_state;
    logic [2:0] r_timer;
    logic [2:0] r_lcd_cmd;
    logic [7:0] r_issued;

    logic       w_full;
    logic       w_grant1;
    logic       w_open;
    logic       w_push;
    logic       w_pop;
    logic [3:0] w_push_data;
    logic       w_unused_src;

    assign w_full      = (r_cnt == C_DEPTH);
    // Lone valid requester wins outright; the pointer only breaks ties.
    assign w_grant1    = req1_valid && (!req0_valid || r_rr);
    assign w_open      = !w_full && !r_sealed;
    assign req0_ready  = w_open && !w_grant1;
    assign req1_ready  = w_open && w_grant1;
    assign w_push      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign w_push_data = w_grant1 ? {1'b1, req1_cmd} : {1'b0, req0_cmd};
    assign w_pop       = (r_state == S_IDLE) && (r_cnt != 3'd0) && !lcd_busy;
    assign w_unused_src = r_mem[r_rd_ptr][3];

    assign lcd_cmd       = r_lcd_cmd;
    assign lcd_cmd_valid = (r_state == S_ISSUE) && !reset;
    assign fifo_cnt      = r_cnt;
    assign issued_cnt    = r_issued;
    assign sealed        = r_sealed;
    assign all_done      = (r_state == S_FINISHED);
    assign err_timeout   = r_err;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_cnt    <= 3'd0;
            r_rr     <= 1'b0;
            r_sealed <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
                r_rr     <= !w_grant1;
                if (w_push_data[2:0] == C_WRITE) begin
                    r_sealed <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 3'd1;
                2'b01:   r_cnt <= r_cnt - 3'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_timer   <= 3'd0;
            r_lcd_cmd <= 3'd0;
            r_issued  <= 8'd0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Head is latched as it is popped; the strobe follows in ISSUE.
                    if (w_pop) begin
                        r_lcd_cmd <= r_mem[r_rd_ptr][2:0];
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_issued != C_CNT_MAX) begin
                        r_issued <= r_issued + 8'd1;
                    end
                    r_timer <= 3'd1;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (lcd_busy) begin
                        r_state <= S_WAIT_IDLE;
                    end else if (r_timer == C_TIMEOUT) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 3'd1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (!lcd_busy) begin
                        r_state <= (r_lcd_cmd == C_WRITE) ? S_WAIT_DONE : S_IDLE;
                    end
                end
                S_WAIT_DONE: begin
                    if (lcd_done) begin
                        r_state <= S_FINISHED;
                    end
                end
                S_FINISHED: r_state <= S_FINISHED;
                default:    r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_cmd_sched
// Purpose  : Directed self-checking bench for lcd_cmd_sched.
// Revision : 1.0
// ============================================================================
module tb_lcd_cmd_sched;

    logic       clk;
    logic       reset;
    logic [2:0] req0_cmd;
    logic       req0_valid;
    logic       req0_ready;
    logic [2:0] req1_cmd;
    logic       req1_valid;
    logic       req1_ready;
    logic [2:0] lcd_cmd;
    logic       lcd_cmd_valid;
    logic       lcd_busy;
    logic       lcd_done;
    logic [2:0] fifo_cnt;
    logic [7:0] issued_cnt;
    logic       sealed;
    logic       all_done;
    logic       err_timeout;

    logic       busy_force;
    logic       resp_busy;
    logic       resp_en;
    int         n_total;
    int         n_bad;
    int         cyc;
    int         strobe_cnt;
    int         last_strobe_cyc;
    int         max_cnt;
    logic [2:0] cmd_log[$];

    assign lcd_busy = busy_force | resp_busy;

    lcd_cmd_sched dut (
        .clk          (clk),
        .reset        (reset),
        .req0_cmd     (req0_cmd),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req1_cmd     (req1_cmd),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .lcd_cmd      (lcd_cmd),
        .lcd_cmd_valid(lcd_cmd_valid),
        .lcd_busy     (lcd_busy),
        .lcd_done     (lcd_done),
        .fifo_cnt     (fifo_cnt),
        .issued_cnt   (issued_cnt),
        .sealed       (sealed),
        .all_done     (all_done),
        .err_timeout  (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Strobe monitor, sampled just after each rising edge.
    initial begin
        cyc = 0;
        strobe_cnt = 0;
        last_strobe_cyc = 0;
        max_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (reset) begin
                strobe_cnt = 0;
                max_cnt = 0;
                cmd_log.delete();
            end else begin
                if (lcd_cmd_valid) begin
                    strobe_cnt++;
                    last_strobe_cyc = cyc;
                    cmd_log.push_back(lcd_cmd);
                end
                if (int'(fifo_cnt) > max_cnt) max_cnt = int'(fifo_cnt);
            end
        end
    end

    // LCD model: busy rises the cycle after a strobe and stays up for three cycles.
    initial begin
        resp_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_en && lcd_cmd_valid && !reset) begin
                @(posedge clk);
                #1;
                resp_busy = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                resp_busy = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int log_at(input int i);
        if (i < cmd_log.size()) return int'(cmd_log[i]);
        return -1;
    endfunction

    task automatic do_reset();
        resp_en = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lcd_done = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push(input bit src, input logic [2:0] cmd, input string tag);
        int n = 0;
        @(negedge clk);
        if (src) begin req1_valid = 1'b1; req1_cmd = cmd; end
        else     begin req0_valid = 1'b1; req0_cmd = cmd; end
        #1;
        while (!(src ? req1_ready : req0_ready) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(tag, (n < 200) ? 1 : 0, 1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget, input string tag);
        int k = 0;
        while (strobe_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, (strobe_cnt >= n) ? 1 : 0, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cnt"},    int'(fifo_cnt), 0);
        chk({tag, "_cmd"},    int'(lcd_cmd), 0);
        chk({tag, "_vld"},    int'(lcd_cmd_valid), 0);
        chk({tag, "_issued"}, int'(issued_cnt), 0);
        chk({tag, "_sealed"}, int'(sealed), 0);
        chk({tag, "_done"},   int'(all_done), 0);
        chk({tag, "_err"},    int'(err_timeout), 0);
    endtask

    initial begin
        n_total = 0;
        n_bad = 0;
        reset = 1'b1;
        req0_cmd = 3'd0;
        req1_cmd = 3'd0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lcd_done = 1'b0;
        busy_force = 1'b0;
        resp_en = 1'b0;

        // Reset values, with the LCD still busy loading its ROM.
        busy_force = 1'b1;
        do_reset();
        @(negedge clk);
        chk_reset_vals("rst");

        // Command queued during a 64-cycle post-reset busy window.
        push(1'b0, 3'd2, "rom_push");
        repeat (60) @(negedge clk);
        chk("rom_no_strobe", strobe_cnt, 0);
        chk("rom_cnt", int'(fifo_cnt), 1);
        busy_force = 1'b0;
        resp_en = 1'b1;
        wait_strobes(1, 50, "rom_wait");
        chk("rom_cmd", log_at(0), 2);
        repeat (3) @(negedge clk);
        chk("rom_issued", int'(issued_cnt), 1);
        chk("rom_one_strobe", strobe_cnt, 1);

        // Both requesters continuously valid: strict alternation.
        do_reset();
        resp_en = 1'b1;
        @(negedge clk);
        req0_cmd = 3'd1; req0_valid = 1'b1;
        req1_cmd = 3'd4; req1_valid = 1'b1;
        wait_strobes(4, 200, "rr_wait");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), log_at(i), (i % 2 == 0) ? 1 : 4);
        chk("rr_max_cnt", max_cnt, 4);

        // Five pushes against a held-busy LCD.
        busy_force = 1'b1;
        do_reset();
        push(1'b0, 3'd3, "full_p0");
        push(1'b0, 3'd5, "full_p1");
        push(1'b0, 3'd6, "full_p2");
        push(1'b0, 3'd7, "full_p3");
        @(negedge clk);
        req0_cmd = 3'd1; req0_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("full_cnt", int'(fifo_cnt), 4);
        chk("full_rdy0", int'(req0_ready), 0);
        chk("full_rdy1", int'(req1_ready), 0);
        chk("full_no_strobe", strobe_cnt, 0);
        busy_force = 1'b0;
        resp_en = 1'b1;
        wait_strobes(1, 50, "full_wait");
        chk("full_first_cmd", int'(lcd_cmd), 3);
        chk("full_cnt_pop", int'(fifo_cnt), 3);
        chk("full_rdy0_open", int'(req0_ready), 1);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("full_cnt_refill", int'(fifo_cnt), 4);
        wait_strobes(5, 200, "full_drain");
        for (int i = 0; i < 5; i++) begin
            int exp_cmd;
            case (i)
                0: exp_cmd = 3;
                1: exp_cmd = 5;
                2: exp_cmd = 6;
                3: exp_cmd = 7;
                default: exp_cmd = 1;
            endcase
            chk($sformatf("full_order%0d", i), log_at(i), exp_cmd);
        end

        // Write command seals the queue; completion after lcd_done.
        busy_force = 1'b1;
        do_reset();
        push(1'b1, 3'd7, "seal_p7");
        push(1'b0, 3'd0, "seal_p0");
        chk("seal_flag", int'(sealed), 1);
        req0_cmd = 3'd5; req0_valid = 1'b1;
        req1_cmd = 3'd6; req1_valid = 1'b1;
        #1;
        chk("seal_rdy0", int'(req0_ready), 0);
        chk("seal_rdy1", int'(req1_ready), 0);
        repeat (3) @(negedge clk);
        chk("seal_cnt", int'(fifo_cnt), 2);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        busy_force = 1'b0;
        resp_en = 1'b1;
        wait_strobes(2, 100, "seal_wait");
        chk("seal_order0", log_at(0), 7);
        chk("seal_order1", log_at(1), 0);
        repeat (12) @(negedge clk);
        chk("seal_not_done", int'(all_done), 0);
        lcd_done = 1'b1;
        @(negedge clk);
        lcd_done = 1'b0;
        chk("seal_all_done", int'(all_done), 1);
        repeat (5) @(negedge clk);
        chk("seal_done_hold", int'(all_done), 1);
        chk("seal_strobes", strobe_cnt, 2);

        // LCD never acknowledges: timeout eight cycles after the strobe.
        busy_force = 1'b0;
        do_reset();
        push(1'b0, 3'd5, "tmo_p5");
        push(1'b0, 3'd6, "tmo_p6");
        wait_strobes(1, 50, "tmo_wait");
        begin
            int s;
            int k;
            s = last_strobe_cyc;
            k = 0;
            while (cyc < s + 7 && k < 50) begin
                @(negedge clk);
                k++;
            end
        end
        chk("tmo_err_early", int'(err_timeout), 0);
        @(negedge clk);
        chk("tmo_err_set", int'(err_timeout), 1);
        wait_strobes(2, 20, "tmo_next");
        chk("tmo_next_cmd", log_at(1), 6);
        chk("tmo_sticky", int'(err_timeout), 1);

        // Reset while parked in WAIT_IDLE with three entries queued.
        do_reset();
        push(1'b0, 3'd1, "mid_p1");
        wait_strobes(1, 20, "mid_wait");
        busy_force = 1'b1;
        push(1'b0, 3'd2, "mid_p2");
        push(1'b1, 3'd3, "mid_p3");
        push(1'b0, 3'd4, "mid_p4");
        repeat (2) @(negedge clk);
        chk("mid_cnt", int'(fifo_cnt), 3);
        chk("mid_issued", int'(issued_cnt), 1);
        reset = 1'b1;
        #1;
        chk("mid_vld_in_rst", int'(lcd_cmd_valid), 0);
        @(negedge clk);
        chk_reset_vals("mid");
        reset = 1'b0;
        busy_force = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_no_strobe", strobe_cnt, 0);

        // issued_cnt saturates at 255.
        do_reset();
        resp_en = 1'b1;
        @(negedge clk);
        req0_cmd = 3'd2; req0_valid = 1'b1;
        wait_strobes(257, 4000, "sat_wait");
        req0_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("sat_issued", int'(issued_cnt), 255);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
